// File: rtl/quad_gen_if.sv
// Request channel into the quadrature generator: valid/ready handshake plus request fields.
// Latency: none, wires only.
// Backpressure: the master holds req_valid and the fields until req_ready is seen high.
interface quad_gen_if #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic             req_dir;
    logic [CNT_W-1:0] req_count;
    logic [DIV_W-1:0] half_period;

    modport master (
        output req_valid,
        output req_dir,
        output req_count,
        output half_period,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dir,
        input  req_count,
        input  half_period,
        output req_ready
    );
endinterface

// File: rtl/quad_gen.sv
// Quadrature encoder emulator: each requested count becomes two a/b phase transitions.
// Latency: first edge hp cycles after accept, then one edge every hp cycles; done on the last edge's cycle.
// Backpressure: req_ready is high only in IDLE; request fields are latched at accept and ignored afterwards.
module quad_gen #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 16,
    parameter int POS_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    quad_gen_if.slave        req,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);
    localparam int EW = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             dir_q;
    logic             abort_q;
    logic [DIV_W-1:0] hp_q;
    logic [DIV_W-1:0] timer;
    logic [EW-1:0]    edges_left;

    logic [DIV_W-1:0] hp_in;
    logic             accept;
    logic             at_boundary;
    logic             stop_now;
    logic             edge_now;
    logic             last_edge;
    logic [1:0]       phase_nxt;

    // A zero half period would never fire the timer, so it is promoted to one cycle.
    assign hp_in       = (req.half_period == '0) ? DIV_W'(1) : req.half_period;
    assign accept      = (state == S_IDLE) && req.req_valid && !reset;
    // Phase 00 or 11 means the decoder sits on a whole count.
    assign at_boundary = (a == b);
    // Abort wins over a coinciding edge only when no half-count is outstanding.
    assign stop_now    = (state == S_RUN) && (abort || abort_q) && at_boundary;
    assign edge_now    = (state == S_RUN) && !stop_now && (timer == DIV_W'(1));
    assign last_edge   = edge_now && (edges_left == EW'(1));

    // Next {a,b} one step along the up or down Gray sequence.
    always_comb begin
        phase_nxt = 2'b00;
        if (dir_q) begin
            case ({a, b})
                2'b00:   phase_nxt = 2'b10;
                2'b10:   phase_nxt = 2'b11;
                2'b11:   phase_nxt = 2'b01;
                default: phase_nxt = 2'b00;
            endcase
        end else begin
            case ({a, b})
                2'b00:   phase_nxt = 2'b01;
                2'b01:   phase_nxt = 2'b11;
                2'b11:   phase_nxt = 2'b10;
                default: phase_nxt = 2'b00;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: a zero-count request or a finished/aborted run goes through the one-cycle DONE state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (req.req_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (stop_now || last_edge) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        req.req_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            S_IDLE:  req.req_ready = !reset;
            S_RUN:   busy          = 1'b1;
            S_DONE:  done          = 1'b1;
            default: ;
        endcase
    end

    // Request latch, edge timer, phase outputs and running position.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q      <= 1'b0;
            abort_q    <= 1'b0;
            hp_q       <= DIV_W'(1);
            timer      <= DIV_W'(1);
            edges_left <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            pos        <= '0;
        end else if (accept) begin
            dir_q      <= req.req_dir;
            abort_q    <= 1'b0;
            hp_q       <= hp_in;
            timer      <= hp_in;
            edges_left <= {req.req_count, 1'b0};
        end else if (state == S_RUN) begin
            abort_q <= abort_q | abort;
            if (edge_now) begin
                {a, b}     <= phase_nxt;
                edges_left <= edges_left - EW'(1);
                timer      <= hp_q;
                if (phase_nxt[1] == phase_nxt[0]) begin
                    pos <= dir_q ? pos + POS_W'(1) : pos - POS_W'(1);
                end
            end else if (!stop_now) begin
                timer <= timer - DIV_W'(1);
            end
        end
    end
endmodule
